absorb_pad_stage: RTL and testbench
===================================

# absorb_pad_stage

Input stage of the SHAKE core, feeding the permute/dump datapath. It accepts a per-message header (mode, input byte count, output byte count) and a stream of w-bit message words. It assembles them into rate-sized blocks with SHAKE padding (0x1F … 0x80). Each finished block, with its control fields, is handed to the permute stage over a valid/ready interface.

## Interface
- SIZE_WIDTH, 32, width of input/output byte counts.
- Widths otherwise come from keccak_pkg: w=64, RATE_SHAKE128=1344, RATE_SHAKE256=1088, SHAKE128_MODE_VEC, SHAKE256_MODE_VEC.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- header_valid  in  1  header fields valid.
- header_ready  out  1  stage can take a header (IDLE only).
- operation_mode_in  in  2  SHAKE128_MODE_VEC or SHAKE256_MODE_VEC.
- input_size_in  in  SIZE_WIDTH  message length, bytes.
- output_size_in  in  SIZE_WIDTH  requested output length, bytes; passed through.
- data_in  in  w  message word; byte 0 in data_in[7:0].
- data_valid  in  1  data_in valid.
- data_ready  out  1  stage accepts a word this cycle.
- rate_output  out  RATE_SHAKE128  assembled, padded block.
- block_valid  out  1  rate_output and control outputs valid.
- block_ready  in  1  permute stage takes the block.
- last_block  out  1  current block is the final, padded one.
- operation_mode_out  out  2  latched mode.
- output_size_out  out  SIZE_WIDTH  latched output size.

## Operation
- Block geometry:
  - SHAKE128: 21 words (168 B).
  - SHAKE256: 17 words (136 B).
- Word placement: word j of a block goes to rate_output[RB-1-w*j -: w], where RB = 1344 or 1088.
  - The word is stored byte-reversed: data_in[7:0] lands in the MS byte of its slot.
  - This matches the whole-rate byte swap used on the dump side.
  - In SHAKE256 mode, bits [1343:1088] are zero.
- Message byte k of a block (k=0 first) therefore occupies rate_output[RB-1-8k -: 8].
- FSM states:
  - IDLE:
    - header_ready=1.
    - On header_valid: latch mode, input size into remaining-bytes counter, and output size; clear buffer.
    - If size=0, go to PAD. Otherwise go to FILL.
    - An invalid mode is consumed and ignored; stay in IDLE.
  - FILL:
    - data_ready=1.
    - On accept, write the word at slot word_cnt and increment word_cnt.
    - remaining -= min(8, remaining). Bytes beyond remaining in a partial last word are forced to 0.
    - Exit to PAD when remaining reaches 0 with bytes still free in the block.
    - Exit to HOLD (non-final) when word_cnt reaches the block size while remaining > 0 or remaining == 0 after an exact fill.
  - PAD (1 cycle):
    - XOR 0x1F into message byte index (input bytes mod block bytes).
    - XOR 0x80 into byte RB/8-1.
    - Set last_block. Go to HOLD.
  - HOLD:
    - block_valid=1. Outputs remain stable until block_ready.
    - On block_ready, clear buffer and word_cnt, then:
      - if last_block, go to IDLE;
      - else if remaining == 0 (exact multiple of rate), go to PAD to build a padding-only block;
      - else go to FILL.
- Padding boundary cases:
  - Message ending at block byte RB/8-1: that byte becomes 0x9F.
  - Message length an exact multiple of the rate (including 0): an extra block is emitted that contains only 0x1F at byte 0 and 0x80 at the last byte.
- Blocks per message: floor(input_size / rate_bytes) + 1.
- operation_mode_out and output_size_out hold from header accept until the next header.

## Timing
- Reset (rst=0 at an edge):
  - state=IDLE; header_ready=1; data_ready=0; block_valid=0; last_block=0.
  - rate_output=0; operation_mode_out=0; output_size_out=0; counters=0.
- Reset mid-message abandons the message; no partial block is ever presented.
- Header accept → data_ready=1 on the next cycle.
- Last word of a full non-final block accepted at cycle N → block_valid=1 at N+1.
- Last message word accepted at N → PAD at N+1 → block_valid=1 at N+2.
- block_valid and block_ready high at cycle N → next FILL (data_ready=1) at N+1.
- No word is accepted while in HOLD or PAD, so there is no overlap between a held block and new data. data_valid may be held high arbitrarily.
- header_valid outside IDLE is ignored; header_ready=0.

## Test plan
- Reset, then SHAKE128 header with input_size=0, output_size=32 → after 2 cycles:
  - exactly one block, last_block=1;
  - byte 0 = 0x1F, byte 167 = 0x80, all other rate_output bits 0;
  - output_size_out=32.
- SHAKE256, input_size=3, one word 0x…636261 → one block:
  - bytes 0..3 = 61 62 63 1F; byte 135 = 0x80;
  - garbage bytes of the partial word are zeroed; bits [1343:1088] = 0.
- SHAKE256, input_size=135 (17 words) → single block with byte 134 = data and byte 135 = 0x9F.
- SHAKE256, input_size=136 → two blocks:
  - first non-final with all data;
  - second last_block=1, containing only 0x1F/0x80 padding.
- SHAKE128, input_size=400 with random data_valid gaps and block_ready held low for 5 cycles:
  - 3 blocks; rate_output stable during the stall;
  - data_ready=0 in HOLD; 0x1F at byte 64 of block 2.
- rst=0 for one cycle during FILL → IDLE with all outputs at reset values; a new header then completes normally.

Source files
------------

// File: rtl/absorb_pad_stage_if.sv
//============================================================================
// Module      : absorb_pad_stage_if
// Description : Header, message-word and block handshake bundle between the
//               message source, the absorb/pad stage and the permute stage.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface absorb_pad_stage_if #(
    parameter int SIZE_WIDTH    = 32,
    parameter int W             = 64,
    parameter int RATE_SHAKE128 = 1344
);
    logic                      header_valid;
    logic                      header_ready;
    logic [1:0]                operation_mode_in;
    logic [SIZE_WIDTH-1:0]     input_size_in;
    logic [SIZE_WIDTH-1:0]     output_size_in;
    logic [W-1:0]              data_in;
    logic                      data_valid;
    logic                      data_ready;
    logic [RATE_SHAKE128-1:0]  rate_output;
    logic                      block_valid;
    logic                      block_ready;
    logic                      last_block;
    logic [1:0]                operation_mode_out;
    logic [SIZE_WIDTH-1:0]     output_size_out;

    // Source / sink side: drives headers, words and block_ready
    modport master (
        output header_valid, operation_mode_in, input_size_in, output_size_in,
        output data_in, data_valid, block_ready,
        input  header_ready, data_ready, rate_output, block_valid, last_block,
        input  operation_mode_out, output_size_out
    );

    // Stage side
    modport slave (
        input  header_valid, operation_mode_in, input_size_in, output_size_in,
        input  data_in, data_valid, block_ready,
        output header_ready, data_ready, rate_output, block_valid, last_block,
        output operation_mode_out, output_size_out
    );
endinterface

`default_nettype wire

// File: rtl/absorb_pad_stage.sv
//============================================================================
// Module      : absorb_pad_stage
// Description : SHAKE input stage - packs message words into rate blocks,
//               applies 0x1F..0x80 padding and hands blocks to permute.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module absorb_pad_stage #(
    parameter int         SIZE_WIDTH        = 32,
    parameter logic [1:0] SHAKE128_MODE_VEC = 2'b01,
    parameter logic [1:0] SHAKE256_MODE_VEC = 2'b10
) (
    input  wire logic           clk,
    input  wire logic           rst,
    absorb_pad_stage_if.slave   bus
);

    localparam int c_w        = 64;
    localparam int c_rate128  = 1344;
    localparam int c_rate256  = 1088;
    localparam logic [4:0]  c_words128 = 5'(c_rate128 / c_w);
    localparam logic [4:0]  c_words256 = 5'(c_rate256 / c_w);
    localparam logic [7:0]  c_bytes128 = 8'(c_rate128 / 8);
    localparam logic [7:0]  c_bytes256 = 8'(c_rate256 / 8);
    localparam logic [10:0] c_msb128   = 11'(c_rate128 - 1);
    localparam logic [10:0] c_msb256   = 11'(c_rate256 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_PAD  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [c_rate128-1:0]    r_rate;
    logic [1:0]              r_mode;
    logic [SIZE_WIDTH-1:0]   r_out_size;
    logic [SIZE_WIDTH-1:0]   r_remaining;
    logic [4:0]              r_word_cnt;
    logic [7:0]              r_pad_idx;
    logic                    r_last;

    logic                    w_mode_ok;
    logic                    w_is128;
    logic [4:0]              w_blk_words;
    logic [7:0]              w_blk_bytes;
    logic [10:0]             w_rb_msb;
    logic [3:0]              w_take;
    logic [SIZE_WIDTH-1:0]   w_rem_next;
    logic [7:0]              w_fill_bytes;
    logic [4:0]              w_cnt_next;
    logic [10:0]             w_word_msb;
    logic [10:0]             w_pad_msb;
    logic [c_w-1:0]          w_word;
    logic [c_rate128-1:0]    w_padded;

    always_comb begin
        w_mode_ok    = (bus.operation_mode_in == SHAKE128_MODE_VEC) ||
                       (bus.operation_mode_in == SHAKE256_MODE_VEC);
        w_is128      = (r_mode == SHAKE128_MODE_VEC);
        w_blk_words  = w_is128 ? c_words128 : c_words256;
        w_blk_bytes  = w_is128 ? c_bytes128 : c_bytes256;
        w_rb_msb     = w_is128 ? c_msb128   : c_msb256;
        w_take       = (r_remaining[SIZE_WIDTH-1:3] != '0) ? 4'd8 : {1'b0, r_remaining[2:0]};
        w_rem_next   = r_remaining - SIZE_WIDTH'(w_take);
        w_fill_bytes = {r_word_cnt, 3'b000} + {4'b0000, w_take};
        w_cnt_next   = r_word_cnt + 5'd1;
        w_word_msb   = w_rb_msb - {r_word_cnt, 6'b000000};
        w_pad_msb    = w_rb_msb - {r_pad_idx, 3'b000};

        // Byte-reverse the word so message byte 0 sits in the MS byte of its slot
        w_word = '0;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < w_take) begin
                w_word[c_w-1-8*b -: 8] = bus.data_in[8*b +: 8];
            end
        end

        // Both pad bytes coincide when the message ends one byte short of the block
        w_padded = r_rate;
        if (r_state == S_PAD) begin
            w_padded[w_pad_msb -: 8] = w_padded[w_pad_msb -: 8] ^ 8'h1F;
            w_padded[7:0]            = w_padded[7:0] ^ 8'h80;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        bus.header_ready = 1'b0;
        bus.data_ready   = 1'b0;
        bus.block_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.header_ready = 1'b1;
                if (bus.header_valid && w_mode_ok) begin
                    w_state_next = (bus.input_size_in == '0) ? S_PAD : S_FILL;
                end
            end
            S_FILL: begin
                bus.data_ready = 1'b1;
                if (bus.data_valid) begin
                    if ((w_rem_next == '0) && (w_fill_bytes < w_blk_bytes)) begin
                        w_state_next = S_PAD;
                    end else if (w_cnt_next == w_blk_words) begin
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_PAD: begin
                w_state_next = S_HOLD;
            end
            S_HOLD: begin
                bus.block_valid = 1'b1;
                if (bus.block_ready) begin
                    if (r_last) begin
                        w_state_next = S_IDLE;
                    end else if (r_remaining == '0) begin
                        w_state_next = S_PAD;
                    end else begin
                        w_state_next = S_FILL;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rate      <= '0;
            r_mode      <= '0;
            r_out_size  <= '0;
            r_remaining <= '0;
            r_word_cnt  <= '0;
            r_pad_idx   <= '0;
            r_last      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.header_valid && w_mode_ok) begin
                        r_mode      <= bus.operation_mode_in;
                        r_out_size  <= bus.output_size_in;
                        r_remaining <= bus.input_size_in;
                        r_rate      <= '0;
                        r_word_cnt  <= '0;
                        r_pad_idx   <= '0;
                        r_last      <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (bus.data_valid) begin
                        r_rate[w_word_msb -: c_w] <= w_word;
                        r_word_cnt  <= w_cnt_next;
                        r_remaining <= w_rem_next;
                        r_pad_idx   <= (w_fill_bytes < w_blk_bytes) ? w_fill_bytes : 8'd0;
                    end
                end
                S_PAD: begin
                    r_rate <= w_padded;
                    r_last <= 1'b1;
                end
                S_HOLD: begin
                    if (bus.block_ready) begin
                        r_rate     <= '0;
                        r_word_cnt <= '0;
                        r_pad_idx  <= '0;
                        r_last     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rate_output        = r_rate;
    assign bus.last_block         = r_last;
    assign bus.operation_mode_out = r_mode;
    assign bus.output_size_out    = r_out_size;

endmodule

`default_nettype wire

// File: tb/tb_absorb_pad_stage.sv
//============================================================================
// Module      : tb_absorb_pad_stage
// Description : Randomised scoreboard bench for absorb_pad_stage.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_absorb_pad_stage;

    localparam logic [1:0] M128 = 2'b01;
    localparam logic [1:0] M256 = 2'b10;

    typedef struct {
        logic [1343:0] rate;
        logic          last;
        logic [1:0]    mode;
        logic [31:0]   osize;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    exp_t       exp_q[$];
    logic [7:0] msg_mem [0:1023];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         stall_req = -1;
    bit         gap_en    = 1'b0;

    absorb_pad_stage_if #(.SIZE_WIDTH(32), .W(64), .RATE_SHAKE128(1344)) bus ();

    absorb_pad_stage #(.SIZE_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", nm, act, expv);
    endtask

    task automatic chk_rate(input string nm, input logic [1343:0] act, input logic [1343:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            for (int i = 167; i >= 0; i--) begin
                if (act[8*i +: 8] !== expv[8*i +: 8]) begin
                    $display("FAIL %s: bits[%0d:%0d] actual=%h expected=%h", nm, 8*i+7, 8*i,
                             act[8*i +: 8], expv[8*i +: 8]);
                    break;
                end
            end
        end
    endtask

    // Reference: block i holds message bytes i*rb.., last block gets 0x1F after
    // the final message byte and 0x80 in its last byte.
    function automatic void push_expected(input logic [1:0] mode, input int size, input int osize);
        int rb, nb, idx;
        logic [7:0] b;
        logic [1343:0] r;
        exp_t e;
        rb = (mode == M128) ? 168 : 136;
        nb = size / rb + 1;
        for (int bi = 0; bi < nb; bi++) begin
            r = '0;
            for (int k = 0; k < rb; k++) begin
                idx = bi * rb + k;
                b = (idx < size) ? msg_mem[idx] : 8'h00;
                if (bi == nb - 1 && k == size % rb) b = b ^ 8'h1F;
                if (bi == nb - 1 && k == rb - 1)    b = b ^ 8'h80;
                r[rb*8-1-8*k -: 8] = b;
            end
            e.rate  = r;
            e.last  = (bi == nb - 1);
            e.mode  = mode;
            e.osize = 32'(osize);
            exp_q.push_back(e);
        end
    endfunction

    task automatic check_reset_values();
        chk("rst_header_ready", 64'(bus.header_ready), 64'd1);
        chk("rst_data_ready",   64'(bus.data_ready),   64'd0);
        chk("rst_block_valid",  64'(bus.block_valid),  64'd0);
        chk("rst_last_block",   64'(bus.last_block),   64'd0);
        chk("rst_mode_out",     64'(bus.operation_mode_out), 64'd0);
        chk("rst_osize_out",    64'(bus.output_size_out),    64'd0);
        chk_rate("rst_rate_output", bus.rate_output, '0);
    endtask

    task automatic drive_header(input logic [1:0] mode, input int size, input int osize);
        int t;
        @(negedge clk);
        bus.header_valid      = 1'b1;
        bus.operation_mode_in = mode;
        bus.input_size_in     = 32'(size);
        bus.output_size_in    = 32'(osize);
        t = 0;
        while (!bus.header_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("header_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus.header_valid = 1'b0;
    endtask

    task automatic send_msg(input logic [1:0] mode, input int size, input int osize, input int abort_at);
        int nw, t;
        bit ok;
        logic [63:0] wd;
        ok = (mode == M128) || (mode == M256);
        for (int i = 0; i < size; i++) msg_mem[i] = 8'($urandom);
        if (size == 3) begin
            msg_mem[0] = 8'h61; msg_mem[1] = 8'h62; msg_mem[2] = 8'h63;
        end
        if (ok) push_expected(mode, size, osize);
        drive_header(mode, size, osize);
        if (ok && size > 0) chk("data_ready_after_header", 64'(bus.data_ready), 64'd1);
        nw = ok ? (size + 7) / 8 : 0;
        for (int i = 0; i < nw; i++) begin
            if (i == abort_at) begin
                bus.data_valid = 1'b0;
                rst = 1'b0;
                @(negedge clk);
                check_reset_values();
                rst = 1'b1;
                exp_q.delete();
                return;
            end
            if (gap_en && $urandom_range(0, 2) == 0) begin
                bus.data_valid = 1'b0;
                bus.data_in    = {$urandom, $urandom};
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            for (int b = 0; b < 8; b++)
                wd[8*b +: 8] = (8*i + b < size) ? msg_mem[8*i + b] : 8'($urandom);
            bus.data_valid = 1'b1;
            bus.data_in    = wd;
            t = 0;
            while (!bus.data_ready && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 5000) chk("data_timeout", 64'd0, 64'd1);
            @(negedge clk);
        end
        bus.data_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending_blocks", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: drives block_ready, checks held blocks and pops the scoreboard
    initial begin
        int wait_cnt;
        int stall_tgt;
        logic [1343:0] snap;
        logic snap_last;
        exp_t e;
        wait_cnt = 0;
        stall_tgt = 0;
        bus.block_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.block_valid) begin
                chk("data_ready_in_hold",   64'(bus.data_ready),   64'd0);
                chk("header_ready_in_hold", 64'(bus.header_ready), 64'd0);
                if (wait_cnt == 0) begin
                    snap      = bus.rate_output;
                    snap_last = bus.last_block;
                    stall_tgt = (stall_req >= 0) ? stall_req : int'($urandom_range(0, 2));
                end else begin
                    chk_rate("stall_rate_stable", bus.rate_output, snap);
                    chk("stall_last_stable", 64'(bus.last_block), 64'(snap_last));
                end
                if (wait_cnt >= stall_tgt) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_block", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk_rate("block_rate", bus.rate_output, e.rate);
                        chk("block_last",  64'(bus.last_block),         64'(e.last));
                        chk("block_mode",  64'(bus.operation_mode_out), 64'(e.mode));
                        chk("block_osize", 64'(bus.output_size_out),    64'(e.osize));
                    end
                    bus.block_ready = 1'b1;
                    wait_cnt = 0;
                end else begin
                    bus.block_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.block_ready = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin
        bus.header_valid      = 1'b0;
        bus.operation_mode_in = 2'b00;
        bus.input_size_in     = '0;
        bus.output_size_in    = '0;
        bus.data_valid        = 1'b0;
        bus.data_in           = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b1;

        send_msg(M128, 0, 32, -1);
        wait_drain();
        send_msg(M256, 3, 64, -1);
        send_msg(M256, 135, 16, -1);
        send_msg(M256, 136, 200, -1);
        wait_drain();

        // Invalid mode is swallowed: still idle, previous latched fields kept
        drive_header(2'b11, 40, 99);
        repeat (2) @(negedge clk);
        chk("invalid_header_ready", 64'(bus.header_ready), 64'd1);
        chk("invalid_data_ready",   64'(bus.data_ready),   64'd0);
        chk("invalid_mode_kept",    64'(bus.operation_mode_out), 64'(M256));
        chk("invalid_osize_kept",   64'(bus.output_size_out),    64'd200);

        gap_en = 1'b1;
        stall_req = 5;
        send_msg(M128, 400, 48, -1);
        wait_drain();
        stall_req = -1;

        send_msg(M128, 200, 32, 5);
        send_msg(M256, 50, 24, -1);
        wait_drain();

        for (int m = 0; m < 6; m++) begin
            send_msg(($urandom_range(0, 1) == 0) ? M128 : M256,
                     int'($urandom_range(0, 350)), int'($urandom_range(1, 500)), -1);
        end
        wait_drain();

        repeat (3) @(negedge clk);
        chk("final_idle_header_ready", 64'(bus.header_ready), 64'd1);
        chk("final_no_block_valid",    64'(bus.block_valid),  64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
